regfile_sb: RTL and testbench

Parametrised successor to the single-cycle ARM register file, for the pipelined core. It provides three read ports with a fixed PC override and two write ports: port 3 carries ALU or load results, port 4 carries base-register writeback. Optional write-to-read bypass is included. A per-register busy scoreboard tracks outstanding multicycle loads and produces a stall request for the decode stage.

---
 rtl/regfile_sb_if.sv | 32 +++
 rtl/regfile_sb.sv | 112 +++++++++++
 tb/tb_regfile_sb.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
// Register-file bus: three read ports, two write ports, the scoreboard set port and the stall/status outputs.
// Pure wiring. The master drives addresses, enables and write data; the slave returns read data and stall.
interface regfile_sb_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 5
);
  logic [ADDR_W-1:0] ra1, ra2, ra3;
  logic              re1, re2, re3;
  logic [WIDTH-1:0]  rd1, rd2, rd3;
  logic [WIDTH-1:0]  r15;
  logic              we3, we4;
  logic [ADDR_W-1:0] wa3, wa4;
  logic [WIDTH-1:0]  wd3, wd4;
  logic              set_busy;
  logic [ADDR_W-1:0] set_addr;
  logic              stall;
  logic [CNT_W-1:0]  busy_cnt;
  logic              wr_conflict;

  modport master (
    output ra1, ra2, ra3, re1, re2, re3, r15,
    output we3, wa3, wd3, we4, wa4, wd4, set_busy, set_addr,
    input  rd1, rd2, rd3, stall, busy_cnt, wr_conflict
  );

  modport slave (
    input  ra1, ra2, ra3, re1, re2, re3, r15,
    input  we3, wa3, wd3, we4, wa4, wd4, set_busy, set_addr,
    output rd1, rd2, rd3, stall, busy_cnt, wr_conflict
  );
endinterface

// File: rtl/regfile_sb.sv
// 3R/2W register file with PC override, optional write bypass and a load-busy scoreboard that raises stall.
// Reads and stall are combinational; stores, busy_cnt and wr_conflict update 1 cycle later. There is no backpressure.
module regfile_sb #(
  parameter int WIDTH  = 32,
  parameter int NREGS  = 16,
  parameter int ADDR_W = 4,
  parameter int PC_IDX = 15,
  parameter int BYPASS = 1,
  parameter int CNT_W  = 5
) (
  input logic         clk,
  input logic         reset,
  regfile_sb_if.slave bus
);

  logic [WIDTH-1:0]  mem [NREGS];
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_nxt;
  logic [NREGS-1:0]  hit3, hit4, set_hit;
  logic [CNT_W-1:0]  busy_cnt, cnt_nxt;
  logic              wr_conflict;
  logic [ADDR_W-1:0] ra [3];
  logic              re [3];
  logic [WIDTH-1:0]  rdv [3];
  logic              stall_c;

  assign ra[0] = bus.ra1;
  assign ra[1] = bus.ra2;
  assign ra[2] = bus.ra3;
  assign re[0] = bus.re1;
  assign re[1] = bus.re2;
  assign re[2] = bus.re3;

  // Per-register write/set decode; PC and out-of-range addresses never match.
  always_comb begin
    hit3     = '0;
    hit4     = '0;
    set_hit  = '0;
    busy_nxt = '0;
    cnt_nxt  = '0;
    for (int r = 0; r < NREGS; r++) begin
      if (r != PC_IDX) begin
        hit3[r]    = bus.we3 && (bus.wa3 == ADDR_W'(r));
        hit4[r]    = bus.we4 && (bus.wa4 == ADDR_W'(r));
        set_hit[r] = bus.set_busy && (bus.set_addr == ADDR_W'(r));
        // A fresh load issued over a completing write keeps the register busy.
        if (set_hit[r])
          busy_nxt[r] = 1'b1;
        else if (hit3[r] || hit4[r])
          busy_nxt[r] = 1'b0;
        else
          busy_nxt[r] = busy[r];
      end
      cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[r]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < NREGS; r++)
        mem[r] <= '0;
      busy        <= '0;
      busy_cnt    <= '0;
      wr_conflict <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (hit3[r])
          mem[r] <= bus.wd3;
        else if (hit4[r])
          mem[r] <= bus.wd4;
      end
      busy        <= busy_nxt;
      busy_cnt    <= cnt_nxt;
      wr_conflict <= bus.we3 && bus.we4 && (bus.wa3 == bus.wa4);
    end
  end

  // Read mux priority: PC override, then port 3 bypass, then port 4 bypass, then storage.
  always_comb begin
    logic bsy;
    logic clr;
    stall_c = 1'b0;
    for (int p = 0; p < 3; p++) begin
      rdv[p] = '0;
      bsy    = 1'b0;
      for (int r = 0; r < NREGS; r++) begin
        if (ra[p] == ADDR_W'(r)) begin
          rdv[p] = mem[r];
          bsy    = busy[r];
        end
      end
      clr = (BYPASS != 0) &&
            ((bus.we3 && (bus.wa3 == ra[p])) || (bus.we4 && (bus.wa4 == ra[p])));
      if ((BYPASS != 0) && bus.we4 && (bus.wa4 == ra[p]))
        rdv[p] = bus.wd4;
      if ((BYPASS != 0) && bus.we3 && (bus.wa3 == ra[p]))
        rdv[p] = bus.wd3;
      if (ra[p] == ADDR_W'(PC_IDX))
        rdv[p] = bus.r15;
      if (re[p] && bsy && !clr)
        stall_c = 1'b1;
    end
  end

  assign bus.rd1         = rdv[0];
  assign bus.rd2         = rdv[1];
  assign bus.rd3         = rdv[2];
  assign bus.stall       = stall_c;
  assign bus.busy_cnt    = busy_cnt;
  assign bus.wr_conflict = wr_conflict;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one bypassing instance and one non-bypassing instance fed identical stimulus.
module tb_regfile_sb;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  regfile_sb_if #(.WIDTH(32), .ADDR_W(4), .CNT_W(5)) bus ();
  regfile_sb_if #(.WIDTH(32), .ADDR_W(4), .CNT_W(5)) bus0 ();

  regfile_sb #(.BYPASS(1)) dut    (.clk(clk), .reset(reset), .bus(bus));
  regfile_sb #(.BYPASS(0)) dut_nb (.clk(clk), .reset(reset), .bus(bus0));

  assign bus0.ra1      = bus.ra1;
  assign bus0.ra2      = bus.ra2;
  assign bus0.ra3      = bus.ra3;
  assign bus0.re1      = bus.re1;
  assign bus0.re2      = bus.re2;
  assign bus0.re3      = bus.re3;
  assign bus0.r15      = bus.r15;
  assign bus0.we3      = bus.we3;
  assign bus0.wa3      = bus.wa3;
  assign bus0.wd3      = bus.wd3;
  assign bus0.we4      = bus.we4;
  assign bus0.wa4      = bus.wa4;
  assign bus0.wd4      = bus.wd4;
  assign bus0.set_busy = bus.set_busy;
  assign bus0.set_addr = bus.set_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b0;
    bus.ra1       = '0; bus.ra2 = '0; bus.ra3 = '0;
    bus.re1       = 1'b0; bus.re2 = 1'b0; bus.re3 = 1'b0;
    bus.r15       = '0;
    bus.we3       = 1'b0; bus.wa3 = '0; bus.wd3 = '0;
    bus.we4       = 1'b0; bus.wa4 = '0; bus.wd4 = '0;
    bus.set_busy  = 1'b0; bus.set_addr = '0;

    repeat (2) tick();
    reset = 1'b1;

    // Reset state and PC override
    bus.ra1 = 4'd3; bus.ra2 = 4'd15; bus.r15 = 32'h0000_0108;
    #1;
    chk("rst_rd1", bus.rd1, 32'h0);
    chk("rst_rd2_pc", bus.rd2, 32'h0000_0108);
    chk("rst_busy_cnt", 32'(bus.busy_cnt), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_wr_conflict", 32'(bus.wr_conflict), 32'd0);

    // Write-to-read bypass
    bus.we3 = 1'b1; bus.wa3 = 4'd5; bus.wd3 = 32'hDEAD_BEEF; bus.ra1 = 4'd5;
    #1;
    chk("byp_rd1", bus.rd1, 32'hDEAD_BEEF);
    chk("nobyp_rd1_same", bus0.rd1, 32'h0);
    tick();
    bus.we3 = 1'b0;
    #1;
    chk("byp_rd1_next", bus.rd1, 32'hDEAD_BEEF);
    chk("nobyp_rd1_next", bus0.rd1, 32'hDEAD_BEEF);

    // Dual write to one address: port 3 wins
    bus.we3 = 1'b1; bus.wa3 = 4'd2; bus.wd3 = 32'h11;
    bus.we4 = 1'b1; bus.wa4 = 4'd2; bus.wd4 = 32'h22;
    tick();
    bus.we3 = 1'b0; bus.we4 = 1'b0; bus.ra1 = 4'd2;
    #1;
    chk("conf_r2", bus.rd1, 32'h11);
    chk("conf_flag", 32'(bus.wr_conflict), 32'd1);
    tick();
    chk("conf_flag_clr", 32'(bus.wr_conflict), 32'd0);

    // Writes to PC are discarded
    bus.we3 = 1'b1; bus.wa3 = 4'd15; bus.wd3 = 32'h0000_0BAD; bus.ra2 = 4'd15;
    #1;
    chk("pcw_rd2_same", bus.rd2, 32'h0000_0108);
    tick();
    bus.we3 = 1'b0; bus.r15 = 32'h0000_0200;
    #1;
    chk("pcw_rd2_next", bus.rd2, 32'h0000_0200);

    // Scoreboard set, stall, clear by write
    bus.set_busy = 1'b1; bus.set_addr = 4'd7;
    tick();
    bus.set_busy = 1'b0; bus.re2 = 1'b1; bus.ra2 = 4'd7;
    #1;
    chk("sb_cnt1", 32'(bus.busy_cnt), 32'd1);
    chk("sb_stall", 32'(bus.stall), 32'd1);
    chk("sb_stall_nb", 32'(bus0.stall), 32'd1);
    bus.we3 = 1'b1; bus.wa3 = 4'd7; bus.wd3 = 32'h77;
    #1;
    chk("sb_stall_bypassed", 32'(bus.stall), 32'd0);
    chk("sb_stall_nb_writing", 32'(bus0.stall), 32'd1);
    tick();
    bus.we3 = 1'b0;
    #1;
    chk("sb_cnt_cleared", 32'(bus.busy_cnt), 32'd0);
    chk("sb_stall_cleared", 32'(bus.stall), 32'd0);
    chk("sb_r7", bus.rd2, 32'h77);

    // Set and clear together: set wins
    bus.set_busy = 1'b1; bus.set_addr = 4'd7;
    bus.we4 = 1'b1; bus.wa4 = 4'd7; bus.wd4 = 32'h99;
    tick();
    bus.set_busy = 1'b0; bus.we4 = 1'b0;
    #1;
    chk("sb_setwin_cnt", 32'(bus.busy_cnt), 32'd1);
    chk("sb_setwin_stall", 32'(bus.stall), 32'd1);
    chk("sb_setwin_r7", bus.rd2, 32'h99);
    bus.re2 = 1'b0;
    #1;
    chk("sb_unused_port", 32'(bus.stall), 32'd0);
    bus.we3 = 1'b1; bus.wa3 = 4'd7; bus.wd3 = 32'h0;
    tick();
    bus.we3 = 1'b0;

    // Reset while loads are outstanding
    bus.we3 = 1'b1; bus.wa3 = 4'd1; bus.wd3 = 32'h0000_AAAA;
    tick();
    bus.we3 = 1'b0; bus.set_busy = 1'b1; bus.set_addr = 4'd1;
    tick();
    bus.set_addr = 4'd4;
    tick();
    bus.set_busy = 1'b0; bus.ra1 = 4'd1; bus.re1 = 1'b1;
    #1;
    chk("mid_cnt2", 32'(bus.busy_cnt), 32'd2);
    chk("mid_stall", 32'(bus.stall), 32'd1);
    chk("mid_r1", bus.rd1, 32'h0000_AAAA);
    reset = 1'b0;
    bus.we3 = 1'b1; bus.wa3 = 4'd3; bus.wd3 = 32'h0000_3333;
    tick();
    reset = 1'b1; bus.we3 = 1'b0; bus.ra3 = 4'd3;
    #1;
    chk("mid_rst_cnt", 32'(bus.busy_cnt), 32'd0);
    chk("mid_rst_stall", 32'(bus.stall), 32'd0);
    chk("mid_rst_r1", bus.rd1, 32'h0);
    chk("mid_rst_no_write", bus.rd3, 32'h0);

    // Saturation: PC is never marked busy
    bus.re1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.set_busy = 1'b1; bus.set_addr = 4'(i);
      tick();
    end
    bus.set_busy = 1'b0;
    #1;
    chk("sat_cnt", 32'(bus.busy_cnt), 32'd15);
    bus.re3 = 1'b1; bus.ra3 = 4'd15;
    #1;
    chk("sat_pc_no_stall", 32'(bus.stall), 32'd0);
    bus.ra3 = 4'd9;
    #1;
    chk("sat_r9_stall", 32'(bus.stall), 32'd1);
    bus.set_busy = 1'b1; bus.set_addr = 4'd3;
    tick();
    bus.set_busy = 1'b0;
    #1;
    chk("sat_no_wrap", 32'(bus.busy_cnt), 32'd15);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
